node_feeder: RTL and testbench
==============================

// Module: node_feeder
// PURPOSE
//  Loads one neural node from handshaked streams and returns its result.
//  - Weight/bias words and input-sample words arrive serially.
//  - It assembles them into the packed inputs_t/weights_t/bias_t buses the node consumes.
//  - It waits a fixed evaluation time, captures outputs_t, and returns it as a result beat.
//  - Sits between the syndrome/weight memory sequencer and one node instance.
// PARAMETERS
//  N_INPUTS      16  inputs per node (= input beats per sample)
//  WEIGHT_BITS   3   width of each weight and of the bias
//  INPUT_BITS    3   width of each input element
//  OUTPUT_BITS   3   width of the node output
//  NODE_LATENCY  2   cycles from node buses stable to outputs_t sampled (>=1)
// PORTS
//  clk         in   1                     clock, all state on rising edge
//  reset       in   1                     asynchronous, active-low reset
//  w_valid     in   1                     weight stream word valid
//  w_ready     out  1                     weight stream ready
//  w_data      in   WEIGHT_BITS           weight k (beats 0..N-1), then bias (beat N)
//  w_last      in   1                     high on the bias beat only
//  x_valid     in   1                     input stream word valid
//  x_ready     out  1                     input stream ready
//  x_data      in   INPUT_BITS            input element k on beat k
//  inputs_t    out  N_INPUTS*INPUT_BITS   to node; element k at [k*INPUT_BITS +: INPUT_BITS]
//  weights_t   out  N_INPUTS*WEIGHT_BITS  to node; weight k at [k*WEIGHT_BITS +: WEIGHT_BITS]
//  bias_t      out  WEIGHT_BITS           to node bias
//  outputs_t   in   OUTPUT_BITS           node result
//  r_valid     out  1                     result valid
//  r_ready     in   1                     result consumer ready
//  r_data      out  OUTPUT_BITS           captured node result
//  w_loaded    out  1                     complete weight set + bias held
//  err         out  1                     sticky: w_last framing error
// BEHAVIOUR
//  Reset (reset=0, async):
//   - all outputs 0; counters 0; state W_LOAD; w_loaded=0; err=0
//   - a reset mid-load or mid-eval discards everything
//  Handshake: a word transfers when valid&&ready on a rising edge.
//   - ready never depends combinationally on valid
//   - r_valid/r_data hold stable until r_ready
//  States:
//   W_LOAD
//    - w_ready=1, x_ready=0; w beat k<N writes weight k to weights_t
//    - beat N writes bias_t and requires w_last=1; then w_loaded=1, go X_LOAD
//    - w_last=1 on beat k<N, or w_last=0 on beat N: err=1, w_cnt=0, w_loaded=0, stay W_LOAD
//   X_LOAD
//    - x_ready=1; beat k writes staging element k
//    - w_ready=1 only while x_cnt==0
//    - w and x beats both valid with x_cnt==0: the weight beat wins (x_ready=0 that cycle),
//      w_loaded=0, weight counter starts, go W_LOAD
//    - beat N-1 accepted: staging+last element copied to inputs_t in same edge, go EVAL
//    - inputs_t changes only on that transfer, so the node sees a stable vector
//   EVAL
//    - w_ready=x_ready=0; count NODE_LATENCY cycles after entry
//    - at the final count, r_data<=outputs_t, r_valid<=1, go RESULT
//   RESULT
//    - r_valid=1; on r_ready: r_valid<=0, go X_LOAD (weights/bias retained)
//    - x/w not accepted (no overlap; one sample in flight)
//  Latency: last x beat at edge E; r_valid high after edge E+NODE_LATENCY.
//  Counters: w_cnt 0..N; x_cnt 0..N-1; width clog2(N_INPUTS+1). Wrap to 0 on completion.
//  err clears only on reset. weights_t/bias_t hold the last completed or partial load.
// TESTING
//  1 Reset low mid-X_LOAD (x_cnt=7) -> next cycle all outputs 0, state W_LOAD, x_ready=0.
//  2 N=16: weights k%4, bias 3 (w_last on beat 16), then inputs all 1.
//    -> w_loaded=1; inputs_t=all 3'b001; r_data=model(node) after 2 cycles.
//  3 w_last on beat 5 -> err=1, w_loaded=0; full reload then succeeds, err stays 1.
//  4 r_ready held low 10 cycles -> r_valid and r_data stable, x_ready=0.
//    r_ready=1 -> next sample accepted.
//  5 x_cnt=0, w_valid and x_valid same cycle -> weight accepted, x stalls, state W_LOAD.
//  6 Random valid/ready gaps, 100 samples, fixed weights -> every r_data matches reference model.

Source files
------------

// File: rtl/node_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : node_feeder
// Description : Assembles serial weight/bias and input-sample streams into the
//               packed buses of one neural node, waits a fixed evaluation time
//               and returns the node output as a handshaked result beat.
// Revision    : 1.0 - initial release
// ============================================================================
module node_feeder #(
    parameter int N_INPUTS     = 16,
    parameter int WEIGHT_BITS  = 3,
    parameter int INPUT_BITS   = 3,
    parameter int OUTPUT_BITS  = 3,
    parameter int NODE_LATENCY = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            w_valid,
    output logic                            w_ready,
    input  logic [WEIGHT_BITS-1:0]          w_data,
    input  logic                            w_last,
    input  logic                            x_valid,
    output logic                            x_ready,
    input  logic [INPUT_BITS-1:0]           x_data,
    output logic [N_INPUTS*INPUT_BITS-1:0]  inputs_t,
    output logic [N_INPUTS*WEIGHT_BITS-1:0] weights_t,
    output logic [WEIGHT_BITS-1:0]          bias_t,
    input  logic [OUTPUT_BITS-1:0]          outputs_t,
    output logic                            r_valid,
    input  logic                            r_ready,
    output logic [OUTPUT_BITS-1:0]          r_data,
    output logic                            w_loaded,
    output logic                            err
);

    localparam int c_CNT_W  = $clog2(N_INPUTS + 1);
    localparam int c_EVAL_W = $clog2(NODE_LATENCY + 1);

    typedef enum logic [1:0] {
        W_LOAD = 2'd0,
        X_LOAD = 2'd1,
        EVAL   = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t                          r_state;
    logic [c_CNT_W-1:0]              r_w_cnt;
    logic [c_CNT_W-1:0]              r_x_cnt;
    logic [c_EVAL_W-1:0]             r_eval_cnt;
    logic [N_INPUTS*INPUT_BITS-1:0]  r_stage;

    logic                            w_x_idle;
    logic                            w_wfire;
    logic                            w_xfire;
    logic                            w_is_bias;
    logic                            w_frame_err;
    logic                            w_x_is_last;
    logic [N_INPUTS*INPUT_BITS-1:0]  w_inputs_next;

    assign w_x_idle = (r_x_cnt == '0);

    // A weight beat pre-empts a new sample only before its first input beat,
    // so x_ready looks at w_valid but never at x_valid.
    assign w_ready = reset && ((r_state == W_LOAD) || ((r_state == X_LOAD) && w_x_idle));
    assign x_ready = reset && (r_state == X_LOAD) && !(w_x_idle && w_valid);

    assign w_wfire     = w_valid && w_ready;
    assign w_xfire     = x_valid && x_ready;
    assign w_is_bias   = (r_w_cnt == c_CNT_W'(N_INPUTS));
    assign w_frame_err = (w_last != w_is_bias);
    assign w_x_is_last = (r_x_cnt == c_CNT_W'(N_INPUTS - 1));

    always_comb begin
        w_inputs_next = r_stage;
        w_inputs_next[(N_INPUTS-1)*INPUT_BITS +: INPUT_BITS] = x_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= W_LOAD;
            r_w_cnt    <= '0;
            r_x_cnt    <= '0;
            r_eval_cnt <= '0;
            r_stage    <= '0;
            inputs_t   <= '0;
            weights_t  <= '0;
            bias_t     <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            w_loaded   <= 1'b0;
            err        <= 1'b0;
        end else if (w_wfire) begin
            if (w_frame_err) begin
                err      <= 1'b1;
                r_w_cnt  <= '0;
                w_loaded <= 1'b0;
                r_state  <= W_LOAD;
            end else if (w_is_bias) begin
                bias_t   <= w_data;
                r_w_cnt  <= '0;
                w_loaded <= 1'b1;
                r_state  <= X_LOAD;
            end else begin
                weights_t[r_w_cnt*WEIGHT_BITS +: WEIGHT_BITS] <= w_data;
                r_w_cnt  <= r_w_cnt + c_CNT_W'(1);
                w_loaded <= 1'b0;
                r_state  <= W_LOAD;
            end
        end else begin
            case (r_state)
                X_LOAD: begin
                    if (w_xfire) begin
                        if (w_x_is_last) begin
                            inputs_t   <= w_inputs_next;
                            r_x_cnt    <= '0;
                            r_eval_cnt <= '0;
                            r_state    <= EVAL;
                        end else begin
                            r_stage[r_x_cnt*INPUT_BITS +: INPUT_BITS] <= x_data;
                            r_x_cnt <= r_x_cnt + c_CNT_W'(1);
                        end
                    end
                end
                EVAL: begin
                    if (r_eval_cnt == c_EVAL_W'(NODE_LATENCY - 1)) begin
                        r_data  <= outputs_t;
                        r_valid <= 1'b1;
                        r_state <= RESULT;
                    end else begin
                        r_eval_cnt <= r_eval_cnt + c_EVAL_W'(1);
                    end
                end
                RESULT: begin
                    if (r_ready) begin
                        r_valid <= 1'b0;
                        r_state <= X_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_node_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_node_feeder
// Description : Directed plus randomized bench for node_feeder with a
//               behavioural node and reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_node_feeder;

    localparam int N   = 16;
    localparam int WB  = 3;
    localparam int IB  = 3;
    localparam int OB  = 3;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            w_valid = 1'b0;
    logic            w_ready;
    logic [WB-1:0]   w_data = '0;
    logic            w_last = 1'b0;
    logic            x_valid = 1'b0;
    logic            x_ready;
    logic [IB-1:0]   x_data = '0;
    logic [N*IB-1:0] inputs_t;
    logic [N*WB-1:0] weights_t;
    logic [WB-1:0]   bias_t;
    logic [OB-1:0]   outputs_t;
    logic            r_valid;
    logic            r_ready = 1'b0;
    logic [OB-1:0]   r_data;
    logic            w_loaded;
    logic            err;

    int total = 0;
    int bad   = 0;

    logic [2:0] wq [N];
    logic [2:0] bq;
    logic [2:0] xq [N];

    node_feeder #(
        .N_INPUTS(N), .WEIGHT_BITS(WB), .INPUT_BITS(IB),
        .OUTPUT_BITS(OB), .NODE_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .inputs_t(inputs_t), .weights_t(weights_t), .bias_t(bias_t),
        .outputs_t(outputs_t),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .w_loaded(w_loaded), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural node: weighted sum plus bias, folded to 3 bits.
    function automatic logic [2:0] node_fn(input logic [N*IB-1:0] x,
                                           input logic [N*WB-1:0] w,
                                           input logic [WB-1:0] b);
        int s;
        s = int'(b);
        for (int k = 0; k < N; k++)
            s += int'(x[k*IB +: IB]) * int'(w[k*WB +: WB]);
        return 3'((s + (s >> 3) + (s >> 6)) & 7);
    endfunction

    assign outputs_t = node_fn(inputs_t, weights_t, bias_t);

    function automatic logic [N*3-1:0] pack(input logic [2:0] a [N]);
        logic [N*3-1:0] p;
        p = '0;
        for (int k = 0; k < N; k++) p[k*3 +: 3] = a[k];
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_w(input logic [2:0] d, input logic l, input int gap);
        int n;
        n = 0;
        idle(gap);
        w_valid = 1'b1; w_data = d; w_last = l;
        #1;
        while (!w_ready && n < 40) begin @(posedge clk); #1; n++; end
        chk("w_handshake_bound", 64'(n < 40), 64'd1);
        @(posedge clk); #1;
        w_valid = 1'b0; w_last = 1'b0;
    endtask

    task automatic send_x(input logic [2:0] d, input int gap);
        int n;
        n = 0;
        idle(gap);
        x_valid = 1'b1; x_data = d;
        #1;
        while (!x_ready && n < 40) begin @(posedge clk); #1; n++; end
        chk("x_handshake_bound", 64'(n < 40), 64'd1);
        @(posedge clk); #1;
        x_valid = 1'b0;
    endtask

    task automatic load_weights(input int gapmax);
        for (int k = 0; k <= N; k++)
            send_w((k < N) ? wq[k] : bq, k == N, $urandom_range(0, gapmax));
        chk("w_loaded", 64'(w_loaded), 64'd1);
        chk("weights_t", 64'(weights_t), 64'(pack(wq)));
        chk("bias_t", 64'(bias_t), 64'(bq));
    endtask

    // Feeds xq, checks latency, bus contents, result and its hold behaviour.
    task automatic run_sample(input int gapmax, input int hold, input logic poke);
        int n;
        logic [2:0] exp;
        exp = node_fn(pack(xq), pack(wq), bq);
        for (int k = 0; k < N; k++) send_x(xq[k], $urandom_range(0, gapmax));
        n = 0;
        while (!r_valid && n < 10) begin @(posedge clk); #1; n++; end
        chk("latency", 64'(n), 64'(LAT));
        chk("inputs_t", 64'(inputs_t), 64'(pack(xq)));
        chk("r_data", 64'(r_data), 64'(exp));
        if (poke) begin
            w_valid = 1'b1; x_valid = 1'b1; w_data = 3'd7; x_data = 3'd7;
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_r_valid", 64'(r_valid), 64'd1);
            chk("hold_r_data", 64'(r_data), 64'(exp));
            chk("hold_x_ready", 64'(x_ready), 64'd0);
            chk("hold_w_ready", 64'(w_ready), 64'd0);
        end
        w_valid = 1'b0; x_valid = 1'b0;
        r_ready = 1'b1;
        @(posedge clk); #1;
        r_ready = 1'b0;
        chk("r_valid_drop", 64'(r_valid), 64'd0);
        chk("x_ready_after_result", 64'(x_ready), 64'd1);
    endtask

    initial begin
        // Reset values while reset is held low
        idle(2);
        chk("rst_w_ready", 64'(w_ready), 64'd0);
        chk("rst_r_valid", 64'(r_valid), 64'd0);
        chk("rst_weights", 64'(weights_t), 64'd0);
        reset = 1'b1;
        #1;
        chk("post_rst_w_ready", 64'(w_ready), 64'd1);
        chk("post_rst_x_ready", 64'(x_ready), 64'd0);

        // Async reset in the middle of a sample (x_cnt = 7)
        for (int k = 0; k < N; k++) wq[k] = 3'($urandom_range(1, 7));
        bq = 3'($urandom_range(0, 7));
        load_weights(1);
        for (int k = 0; k < 7; k++) send_x(3'($urandom_range(0, 7)), 0);
        reset = 1'b0;
        #1;
        chk("async_weights", 64'(weights_t), 64'd0);
        chk("async_w_loaded", 64'(w_loaded), 64'd0);
        @(posedge clk); #1;
        chk("mid_rst_x_ready", 64'(x_ready), 64'd0);
        chk("mid_rst_w_ready", 64'(w_ready), 64'd0);
        chk("mid_rst_inputs", 64'(inputs_t), 64'd0);
        chk("mid_rst_bias", 64'(bias_t), 64'd0);
        chk("mid_rst_r_data", 64'(r_data), 64'd0);
        chk("mid_rst_err", 64'(err), 64'd0);
        reset = 1'b1;
        #1;
        chk("rel_w_ready", 64'(w_ready), 64'd1);
        chk("rel_x_ready", 64'(x_ready), 64'd0);

        // Weights k%4, bias 3, all inputs 1: hand-computed sum 27 folds to 6
        for (int k = 0; k < N; k++) wq[k] = 3'(k % 4);
        bq = 3'd3;
        load_weights(0);
        chk("t2_err", 64'(err), 64'd0);
        for (int k = 0; k < N; k++) xq[k] = 3'd1;
        run_sample(0, 0, 1'b0);
        chk("t2_r_data_const", 64'(node_fn(pack(xq), pack(wq), bq)), 64'd6);

        // Framing error: w_last on beat 5, then a clean reload
        for (int k = 0; k < 5; k++) send_w(3'($urandom_range(0, 7)), 1'b0, 0);
        send_w(3'd5, 1'b1, 0);
        chk("t3_err", 64'(err), 64'd1);
        chk("t3_w_loaded", 64'(w_loaded), 64'd0);
        chk("t3_x_ready", 64'(x_ready), 64'd0);
        for (int k = 0; k < N; k++) wq[k] = 3'($urandom_range(0, 7));
        bq = 3'($urandom_range(0, 7));
        load_weights(1);
        chk("t3_err_sticky", 64'(err), 64'd1);

        // Result held 10 cycles with both streams offered, then next sample
        for (int k = 0; k < N; k++) xq[k] = 3'($urandom_range(0, 7));
        run_sample(1, 10, 1'b1);
        for (int k = 0; k < N; k++) xq[k] = 3'($urandom_range(0, 7));
        run_sample(0, 0, 1'b0);

        // Simultaneous w and x at x_cnt = 0: weight wins
        for (int k = 0; k < N; k++) wq[k] = 3'($urandom_range(0, 7));
        bq = 3'($urandom_range(0, 7));
        w_valid = 1'b1; w_data = wq[0]; w_last = 1'b0;
        x_valid = 1'b1; x_data = 3'd5;
        #1;
        chk("t5_x_ready_stall", 64'(x_ready), 64'd0);
        chk("t5_w_ready", 64'(w_ready), 64'd1);
        @(posedge clk); #1;
        w_valid = 1'b0; x_valid = 1'b0;
        #1;
        chk("t5_w_loaded", 64'(w_loaded), 64'd0);
        chk("t5_state_wload", 64'({w_ready, x_ready}), 64'b10);
        chk("t5_weight0", 64'(weights_t[2:0]), 64'(wq[0]));
        for (int k = 1; k <= N; k++) send_w((k < N) ? wq[k] : bq, k == N, 0);
        chk("t5_reload", 64'(weights_t), 64'(pack(wq)));
        chk("t5_bias", 64'(bias_t), 64'(bq));
        for (int k = 0; k < N; k++) xq[k] = 3'($urandom_range(0, 7));
        run_sample(0, 0, 1'b0);

        // Randomized samples with gaps against fixed weights
        for (int s = 0; s < 100; s++) begin
            for (int k = 0; k < N; k++) xq[k] = 3'($urandom_range(0, 7));
            run_sample(3, $urandom_range(0, 3), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
